// File: rtl/result_display_sequencer_if.sv
// rtl/result_display_sequencer_if.sv - result/display bundle between regression datapath and display sequencer
interface result_display_sequencer_if #(
  parameter int RESULT_WIDTH = 14
);
  logic                    load;
  logic [RESULT_WIDTH-1:0] slope_in;
  logic [RESULT_WIDTH-1:0] intercept_in;
  logic [RESULT_WIDTH-1:0] det_in;
  logic                    det_invalid;
  logic                    next;
  logic [6:0]              seg;
  logic                    dp;
  logic [1:0]              field;
  logic                    active;

  // Producer side: regression datapath plus user button.
  modport master (
    output load, slope_in, intercept_in, det_in, det_invalid, next,
    input  seg, dp, field, active
  );

  // Consumer side: the display sequencer.
  modport slave (
    input  load, slope_in, intercept_in, det_in, det_invalid, next,
    output seg, dp, field, active
  );
endinterface

// File: rtl/result_display_sequencer.sv
// rtl/result_display_sequencer.sv - steps slope/intercept/det results out to one 7-segment digit
module result_display_sequencer #(
  parameter int          RESULT_WIDTH = 14,
  parameter logic [31:0] HOLD_CYCLES  = 32'd50_000_000
) (
  input logic                      clk,
  input logic                      rst,
  result_display_sequencer_if.slave bus
);

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_LABEL = 3'd1;
  localparam logic [2:0] ST_SIGN  = 3'd2;
  localparam logic [2:0] ST_TENS  = 3'd3;
  localparam logic [2:0] ST_ONES  = 3'd4;

  // Magnitude is one bit wider so the most negative input has an exact absolute value.
  localparam int          MW     = RESULT_WIDTH + 1;
  localparam logic [31:0] RELOAD = HOLD_CYCLES - 32'd1;

  localparam logic [6:0] G_MINUS = 7'h40;
  localparam logic [6:0] G_E     = 7'h79;
  localparam logic [6:0] G_BLANK = 7'h00;

  logic [2:0]       state_q, state_d;
  logic [1:0]       field_q, field_d;
  logic [31:0]      timer_q, timer_d;
  logic             next_q;
  logic [2:0]       sign_q;
  logic [2:0]       ovf_q;
  logic [2:0][3:0]  tens_q;
  logic [2:0][3:0]  ones_q;
  logic             inv_q;
  logic [6:0]       seg_q, seg_d;
  logic             dp_q, dp_d;
  logic             active_q, active_d;

  logic             adv_btn, adv_tmr, adv;
  logic [9:0]       slope_split, intercept_split, det_split;
  logic             cur_sign, cur_ovf;
  logic [3:0]       cur_tens, cur_ones;
  logic             cur_err;

  // Returns {sign, ovf, tens, ones} for one signed result.
  function automatic logic [9:0] split_value(input logic [RESULT_WIDTH-1:0] v);
    logic [MW-1:0] mag;
    logic [3:0]    tens;
    logic [3:0]    ones;
    mag  = v[RESULT_WIDTH-1] ? ({1'b0, ~v} + MW'(1)) : {1'b0, v};
    tens = 4'(mag / MW'(10));
    ones = 4'(mag % MW'(10));
    return {v[RESULT_WIDTH-1], (mag > MW'(99)), tens, ones};
  endfunction

  function automatic logic [6:0] digit_glyph(input logic [3:0] d);
    logic [6:0] g;
    case (d)
      4'd0:    g = 7'h3F;
      4'd1:    g = 7'h06;
      4'd2:    g = 7'h5B;
      4'd3:    g = 7'h4F;
      4'd4:    g = 7'h66;
      4'd5:    g = 7'h6D;
      4'd6:    g = 7'h7D;
      4'd7:    g = 7'h07;
      4'd8:    g = 7'h7F;
      4'd9:    g = 7'h6F;
      default: g = G_E;
    endcase
    return g;
  endfunction

  assign slope_split     = split_value(bus.slope_in);
  assign intercept_split = split_value(bus.intercept_in);
  assign det_split       = split_value(bus.det_in);

  assign adv_btn = bus.next & ~next_q;
  assign adv_tmr = (timer_q == 32'd0);
  assign adv     = adv_btn | adv_tmr;

  // Step sequencing and hold timer; load overrides any advance in the same cycle.
  always_comb begin
    state_d = state_q;
    field_d = field_q;
    timer_d = timer_q;
    if (bus.load) begin
      state_d = ST_LABEL;
      field_d = 2'd0;
      timer_d = RELOAD;
    end else if (state_q != ST_IDLE) begin
      if (adv) begin
        timer_d = RELOAD;
        case (state_q)
          ST_LABEL: state_d = ST_SIGN;
          ST_SIGN:  state_d = ST_TENS;
          ST_TENS:  state_d = ST_ONES;
          ST_ONES: begin
            state_d = ST_LABEL;
            field_d = (field_q == 2'd2) ? 2'd0 : field_q + 2'd1;
          end
          default:  state_d = ST_IDLE;
        endcase
      end else begin
        timer_d = timer_q - 32'd1;
      end
    end
  end

  // Select the latched values of the field about to be shown.
  always_comb begin
    cur_sign = sign_q[0];
    cur_ovf  = ovf_q[0];
    cur_tens = tens_q[0];
    cur_ones = ones_q[0];
    cur_err  = inv_q;
    case (field_d)
      2'd1: begin
        cur_sign = sign_q[1];
        cur_ovf  = ovf_q[1];
        cur_tens = tens_q[1];
        cur_ones = ones_q[1];
        cur_err  = inv_q;
      end
      2'd2: begin
        cur_sign = sign_q[2];
        cur_ovf  = ovf_q[2];
        cur_tens = tens_q[2];
        cur_ones = ones_q[2];
        cur_err  = 1'b0;
      end
      default: ;
    endcase
  end

  // Glyph for the upcoming step, so the outputs register alongside the state.
  always_comb begin
    seg_d    = G_BLANK;
    dp_d     = (state_d == ST_ONES);
    active_d = (state_d != ST_IDLE);
    case (state_d)
      ST_LABEL: begin
        case (field_d)
          2'd0:    seg_d = 7'h6D;
          2'd1:    seg_d = 7'h7C;
          default: seg_d = 7'h5E;
        endcase
      end
      ST_SIGN:  seg_d = cur_sign ? G_MINUS : G_BLANK;
      ST_TENS:  seg_d = (cur_ovf | cur_err) ? G_E : digit_glyph(cur_tens);
      ST_ONES:  seg_d = (cur_ovf | cur_err) ? G_E : digit_glyph(cur_ones);
      default:  seg_d = G_BLANK;
    endcase
  end

  // Sequencer state, result latches and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      field_q  <= 2'd0;
      timer_q  <= RELOAD;
      next_q   <= 1'b0;
      sign_q   <= '0;
      ovf_q    <= '0;
      tens_q   <= '0;
      ones_q   <= '0;
      inv_q    <= 1'b0;
      seg_q    <= G_BLANK;
      dp_q     <= 1'b0;
      active_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      field_q  <= field_d;
      timer_q  <= timer_d;
      next_q   <= bus.next;
      seg_q    <= seg_d;
      dp_q     <= dp_d;
      active_q <= active_d;
      if (bus.load) begin
        sign_q <= {det_split[9], intercept_split[9], slope_split[9]};
        ovf_q  <= {det_split[8], intercept_split[8], slope_split[8]};
        tens_q <= {det_split[7:4], intercept_split[7:4], slope_split[7:4]};
        ones_q <= {det_split[3:0], intercept_split[3:0], slope_split[3:0]};
        inv_q  <= bus.det_invalid;
      end
    end
  end

  assign bus.seg    = seg_q;
  assign bus.dp     = dp_q;
  assign bus.field  = field_q;
  assign bus.active = active_q;

endmodule

// File: tb/tb_result_display_sequencer.sv
// tb/tb_result_display_sequencer.sv - directed self-checking bench for result_display_sequencer
module tb_result_display_sequencer;

  logic clk;
  logic rst;
  int   tests;
  int   fails;
  logic [6:0] exp_tab [0:11];

  result_display_sequencer_if #(.RESULT_WIDTH(14)) a_if ();
  result_display_sequencer_if #(.RESULT_WIDTH(14)) b_if ();

  result_display_sequencer #(.RESULT_WIDTH(14), .HOLD_CYCLES(32'd4)) u_dut_a (
    .clk(clk), .rst(rst), .bus(a_if)
  );

  result_display_sequencer #(.RESULT_WIDTH(14), .HOLD_CYCLES(32'd1000)) u_dut_b (
    .clk(clk), .rst(rst), .bus(b_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_a(input logic [13:0] s, input logic [13:0] i, input logic [13:0] d, input logic inv);
    a_if.slope_in     = s;
    a_if.intercept_in = i;
    a_if.det_in       = d;
    a_if.det_invalid  = inv;
    a_if.load         = 1'b1;
    tick();
    a_if.load         = 1'b0;
  endtask

  task automatic load_b(input logic [13:0] s, input logic [13:0] i, input logic [13:0] d);
    b_if.slope_in     = s;
    b_if.intercept_in = i;
    b_if.det_in       = d;
    b_if.det_invalid  = 1'b0;
    b_if.load         = 1'b1;
    tick();
    b_if.load         = 1'b0;
  endtask

  // Walks one full 12-step loop of the HOLD=4 instance, checking every cycle against exp_tab.
  task automatic run_loop(input string tag);
    int s;
    for (int k = 0; k <= 48; k++) begin
      if (k > 0) tick();
      s = (k / 4) % 12;
      check($sformatf("%s_seg_k%0d", tag, k), {25'd0, a_if.seg}, {25'd0, exp_tab[s]});
      check($sformatf("%s_dp_k%0d", tag, k), {31'd0, a_if.dp}, {31'd0, (s % 4) == 3});
      check($sformatf("%s_field_k%0d", tag, k), {30'd0, a_if.field}, 32'(s / 4));
    end
  endtask

  initial begin
    tests = 0;
    fails = 0;
    rst   = 1'b1;
    a_if.load = 1'b0; a_if.next = 1'b0; a_if.det_invalid = 1'b0;
    a_if.slope_in = '0; a_if.intercept_in = '0; a_if.det_in = '0;
    b_if.load = 1'b0; b_if.next = 1'b0; b_if.det_invalid = 1'b0;
    b_if.slope_in = '0; b_if.intercept_in = '0; b_if.det_in = '0;

    repeat (3) tick();
    rst = 1'b0;
    tick();
    check("rst_seg", {25'd0, a_if.seg}, 32'h00);
    check("rst_dp", {31'd0, a_if.dp}, 32'd0);
    check("rst_field", {30'd0, a_if.field}, 32'd0);
    check("rst_active", {31'd0, a_if.active}, 32'd0);
    for (int k = 0; k < 10; k++) begin
      a_if.next = ~a_if.next;
      tick();
    end
    a_if.next = 1'b0;
    check("idle_seg", {25'd0, a_if.seg}, 32'h00);
    check("idle_active", {31'd0, a_if.active}, 32'd0);
    check("idle_field", {30'd0, a_if.field}, 32'd0);

    // Normal loop: slope 3, intercept 0, det 54.
    exp_tab = '{7'h6D, 7'h00, 7'h3F, 7'h4F,
                7'h7C, 7'h00, 7'h3F, 7'h3F,
                7'h5E, 7'h00, 7'h6D, 7'h66};
    load_a(14'd3, 14'd0, 14'd54, 1'b0);
    check("load_active", {31'd0, a_if.active}, 32'd1);
    run_loop("norm");

    // Negative and overflowing values: -7, -8192, 123.
    exp_tab = '{7'h6D, 7'h40, 7'h3F, 7'h07,
                7'h7C, 7'h40, 7'h79, 7'h79,
                7'h5E, 7'h00, 7'h79, 7'h79};
    load_a(14'h3FF9, 14'h2000, 14'd123, 1'b0);
    run_loop("neg");

    // Invalid determinant: slope and intercept digits become E, det shows 00.
    exp_tab = '{7'h6D, 7'h00, 7'h79, 7'h79,
                7'h7C, 7'h00, 7'h79, 7'h79,
                7'h5E, 7'h00, 7'h3F, 7'h3F};
    load_a(14'd3, 14'd0, 14'd0, 1'b1);
    run_loop("inv");

    // Button advance and timer restart on the HOLD=1000 instance.
    load_b(14'd3, 14'd0, 14'd54);
    check("b_load_seg", {25'd0, b_if.seg}, 32'h6D);
    b_if.next = 1'b1;
    tick();
    check("btn_first", {25'd0, b_if.seg}, 32'h00);
    repeat (4) tick();
    check("btn_held", {25'd0, b_if.seg}, 32'h00);
    b_if.next = 1'b0;
    tick();
    check("btn_release", {25'd0, b_if.seg}, 32'h00);
    b_if.next = 1'b1;
    tick();
    check("btn_pulse1", {25'd0, b_if.seg}, 32'h3F);
    b_if.next = 1'b0;
    tick();
    check("btn_low", {25'd0, b_if.seg}, 32'h3F);
    b_if.next = 1'b1;
    tick();
    check("btn_pulse2", {25'd0, b_if.seg}, 32'h4F);
    check("btn_pulse2_dp", {31'd0, b_if.dp}, 32'd1);
    b_if.next = 1'b0;
    repeat (999) tick();
    check("tmr_hold", {25'd0, b_if.seg}, 32'h4F);
    tick();
    check("tmr_adv", {25'd0, b_if.seg}, 32'h7C);
    check("tmr_adv_field", {30'd0, b_if.field}, 32'd1);

    // Load during intercept TENS with a simultaneous button edge.
    b_if.next = 1'b1;
    tick();
    b_if.next = 1'b0;
    tick();
    b_if.next = 1'b1;
    tick();
    check("mid_tens", {25'd0, b_if.seg}, 32'h3F);
    check("mid_tens_field", {30'd0, b_if.field}, 32'd1);
    b_if.next = 1'b0;
    tick();
    b_if.next = 1'b1;
    load_b(14'h3FF9, 14'h2000, 14'd123);
    b_if.next = 1'b0;
    check("reload_seg", {25'd0, b_if.seg}, 32'h6D);
    check("reload_field", {30'd0, b_if.field}, 32'd0);
    check("reload_dp", {31'd0, b_if.dp}, 32'd0);
    tick();
    b_if.next = 1'b1;
    tick();
    check("reload_sign", {25'd0, b_if.seg}, 32'h40);
    b_if.next = 1'b0;
    tick();
    b_if.next = 1'b1;
    tick();
    check("reload_tens", {25'd0, b_if.seg}, 32'h3F);
    b_if.next = 1'b0;
    tick();
    b_if.next = 1'b1;
    tick();
    check("reload_ones", {25'd0, b_if.seg}, 32'h07);
    b_if.next = 1'b0;

    // Async reset during det ONES.
    load_a(14'd3, 14'd0, 14'd54, 1'b0);
    repeat (44) tick();
    check("pre_rst_seg", {25'd0, a_if.seg}, 32'h66);
    check("pre_rst_dp", {31'd0, a_if.dp}, 32'd1);
    rst = 1'b1;
    #2;
    check("arst_seg", {25'd0, a_if.seg}, 32'h00);
    check("arst_dp", {31'd0, a_if.dp}, 32'd0);
    check("arst_field", {30'd0, a_if.field}, 32'd0);
    check("arst_active", {31'd0, a_if.active}, 32'd0);
    a_if.load = 1'b1;
    tick();
    a_if.load = 1'b0;
    check("load_in_rst", {31'd0, a_if.active}, 32'd0);
    rst = 1'b0;
    tick();
    check("after_rst_active", {31'd0, a_if.active}, 32'd0);
    check("after_rst_seg", {25'd0, a_if.seg}, 32'h00);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/result_display_sequencer.md
# result_display_sequencer

Sequences the regression results (slope, intercept, determinant) out to a single 7-segment digit plus decimal point. It latches the three signed results when the final multiply reports done, then steps through label, sign, tens and ones glyphs for each field. Each step advances on a user `next` press or after an auto-advance timeout. It is the consumer end of the regression datapath and replaces the bare tens/ones splitting at the top level.

## Interface
Parameters:
- RESULT_WIDTH, 14, width of each signed result input (two's complement)
- HOLD_CYCLES, 50_000_000, cycles a step is shown before auto-advance; legal range 2..2^32-1

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- load  in  1  one-cycle pulse; latch all result inputs and restart the sequence (driven by final-multiply done)
- slope_in  in  RESULT_WIDTH  signed slope
- intercept_in  in  RESULT_WIDTH  signed intercept
- det_in  in  RESULT_WIDTH  signed determinant
- det_invalid  in  1  determinant-zero flag from the inverse stage
- next  in  1  synchronous level from the user button; a rising edge advances one step
- seg  out  7  glyph, bit0=a … bit6=g, active-high
- dp  out  1  decimal point; high only during the ONES step
- field  out  2  0=slope, 1=intercept, 2=det; 3 never driven
- active  out  1  high whenever the state is not IDLE

## Operation
- States: IDLE, LABEL, SIGN, TENS, ONES. `field` is a 2-bit counter that wraps 2->0.
- Latch on `load`:
  - Store `sign = value[RESULT_WIDTH-1]` for each field.
  - Store magnitude as an RESULT_WIDTH+1-bit absolute value, so -2^(W-1) is exact.
  - Store `ovf = (mag > 99)`.
  - Store `tens = mag/10` and `ones = mag%10`.
  - Store `det_invalid`.
- After a load: go to LABEL with field=0 and reload the timer.
- Step order: LABEL -> SIGN -> TENS -> ONES -> LABEL of field+1. ONES of field 2 continues to LABEL of field 0; the loop runs until the next load or reset.
- Glyphs:
  - digits 0-9 = 3F, 06, 5B, 4F, 66, 6D, 7D, 07, 7F, 6F (hex)
  - '-' = 40, 'E' = 79, blank = 00
  - label S = 6D, b = 7C, d = 5E
- Per step:
  - LABEL: label for the current field.
  - SIGN: '-' if sign=1, else blank.
  - TENS / ONES: digit glyph. If ovf=1, both show 'E'.
- Invalid determinant (latched `det_invalid`=1):
  - TENS and ONES of slope and intercept show 'E'.
  - The det field shows its latched value normally (expected 0 0).
- Advance (next edge):
  - `next_q` register, reset 0.
  - `adv_btn = next & ~next_q`.
- Advance (timer):
  - The timer counts down from HOLD_CYCLES-1.
  - `adv_tmr` is asserted when the timer reaches 0.
  - The timer reloads on every step change and on load.
- Priority: rst > load > (adv_btn | adv_tmr). Both advance sources in the same cycle advance exactly one step.
- In IDLE: `next` and the timer are ignored; outputs hold their reset values.

## Timing
- Reset values: seg=00, dp=0, field=0, active=0, state=IDLE, timer=HOLD_CYCLES-1, all latches 0.
- `load` sampled at edge N: at edge N outputs are registered from the new values.
  - From N+1: state=LABEL, field=0, seg=6D, active=1.
- All outputs are registered; no combinational path from inputs to outputs.
- Button advance: a rising edge on `next` sampled at edge M changes the step at edge M.
- Timer advance: each step lasts exactly HOLD_CYCLES cycles absent button presses, so a full loop is 12·HOLD_CYCLES cycles.
- `next` held high: advances once only; a new press needs a low cycle first.
- `load` mid-sequence (any state): re-latch and restart at LABEL/field 0 at that edge; a simultaneous advance is discarded.
- `rst` asserted mid-operation: immediate return to reset values, independent of clk.
- `load` while in reset has no effect.

## Test plan
- Reset: assert rst for 3 cycles, then release -> seg=00, dp=0, field=0, active=0. 10 cycles of `next` toggling -> no change.
- Normal loop, HOLD_CYCLES=4: load with slope=3, intercept=0, det=54. Expected seg every 4 cycles:
  - slope: 6D, 00, 3F, 4F(dp=1)
  - intercept: 7C, 00, 3F, 3F(dp=1)
  - det: 5E, 00, 6D, 66(dp=1)
  - then 6D again with field=0.
- Negative and extreme values: slope=-7 -> SIGN 40, TENS 3F, ONES 07. intercept=-8192 (W=14) -> SIGN 40, TENS 79, ONES 79. det=123 -> blank, 79, 79.
- Button, HOLD_CYCLES=1000: pulse `next` high for 5 cycles -> exactly one step advance at the first-high edge. Pulses at cycles 10 and 12 with a low between -> two advances. Timer restarts after each advance.
- Invalid: load with det_invalid=1, det=0, slope=3 -> slope TENS/ONES = 79/79; det TENS/ONES = 3F/3F.
- Load during the intercept TENS step, with `next` rising edge in the same cycle -> next cycle field=0, seg=6D, new values used.
- Async reset during the det ONES step -> outputs return to reset values before the next clk edge.
